// File: rtl/cpu6502_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cpu6502_pkg
//  Description : Shared widths, reset defaults, bus handshake constants and
//                fetch-state encoding for the 6502 core and its front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu6502_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 16'h0000;

    // Request-line levels shared with the core's load/store bus master.
    localparam logic BUS_IDLE   = 1'b0;
    localparam logic BUS_ACTIVE = 1'b1;

    // FETCH_REQ_DROP: a read is still on the bus but its data belongs to a
    // stream that a redirect has already abandoned.
    typedef enum logic [1:0] {
        FETCH_IDLE     = 2'd0,
        FETCH_REQ      = 2'd1,
        FETCH_REQ_DROP = 2'd2
    } fetch_state_e;

    // 16-bit modulo program-counter increment.
    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : byte_fifo
//  Description : DEPTH x WIDTH synchronous FIFO with flush, occupancy count
//                and registered head data (no input-to-output paths).
//  Ports       : clk, rst_n        clock, async active-low reset
//                flush_i           empty the FIFO (wins over push/pop)
//                push_i, wdata_i   write one entry
//                pop_i             drop the head entry
//                rdata_o           head entry
//                count_o           entries held, 0..DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    // Storage needs no reset; only entries below count_o are ever observed.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_prefetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_prefetch_buffer
//  Description : Instruction prefetch stage for the 6502 core. Issues one
//                outstanding byte read at a time, queues returned bytes with
//                their address and hands them to the core over valid/ready.
//                A redirect flushes the queue and restarts fetch.
//  Ports       : clk, rst_n                  clock, async active-low reset
//                redirect, redirect_pc       flush and re-target fetch
//                mem_req/addr/ack/rdata      single-outstanding read bus
//                ib_valid/data/pc/ready      instruction byte stream to core
//                ib_count                    bytes currently queued
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_prefetch_buffer
    import cpu6502_pkg::*;
#(
    parameter int unsigned        DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    redirect,
    input  logic [ADDR_W-1:0]       redirect_pc,
    output logic                    mem_req,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic                    mem_ack,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic                    ib_valid,
    output logic [DATA_W-1:0]       ib_data,
    output logic [ADDR_W-1:0]       ib_pc,
    input  logic                    ib_ready,
    output logic [$clog2(DEPTH):0]  ib_count
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e       state_q;
    logic [ADDR_W-1:0]  fetch_pc_q;   // next byte to request (or the one in flight)
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [ADDR_W-1:0]  head_pc_q;

    logic               w_in_flight;
    logic               w_ack;
    logic               w_push;
    logic               w_pop;
    logic [CNT_W-1:0]   w_count;
    logic [CNT_W-1:0]   w_count_d;
    logic               w_room;
    logic [ADDR_W-1:0]  w_target;
    logic [ADDR_W-1:0]  w_next_pc;

    always_comb begin
        w_in_flight = (state_q != FETCH_IDLE);
        w_ack       = mem_ack & w_in_flight;
        // Acked data is kept only for the live stream and never on a redirect edge.
        w_push      = w_ack & (state_q == FETCH_REQ) & ~redirect;
        w_pop       = ib_valid & ib_ready & ~redirect;
        w_count_d   = redirect ? '0 : (w_count + CNT_W'(w_push) - CNT_W'(w_pop));
        // A new request reserves a slot: it may go out only if the occupancy
        // after this edge leaves room for the byte it will return.
        w_room      = (w_count_d < CNT_W'(DEPTH));
        w_target    = redirect ? redirect_pc : fetch_pc_q;
        w_next_pc   = redirect ? redirect_pc : pc_inc(fetch_pc_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH_IDLE;
            fetch_pc_q <= RESET_PC;
            mem_addr_q <= RESET_PC;
        end else begin
            case (state_q)
                FETCH_IDLE: begin
                    if (redirect || w_room) begin
                        fetch_pc_q <= w_target;
                        mem_addr_q <= w_target;
                        state_q    <= FETCH_REQ;
                    end
                end
                FETCH_REQ: begin
                    if (w_ack) begin
                        // Back-to-back: the next read can go out on the ack edge.
                        fetch_pc_q <= w_next_pc;
                        mem_addr_q <= w_next_pc;
                        state_q    <= w_room ? FETCH_REQ : FETCH_IDLE;
                    end else if (redirect) begin
                        // Bus transaction cannot be aborted; mark its byte as stale.
                        fetch_pc_q <= redirect_pc;
                        state_q    <= FETCH_REQ_DROP;
                    end
                end
                FETCH_REQ_DROP: begin
                    fetch_pc_q <= w_target;
                    if (w_ack) begin
                        // Queue is empty since the redirect, so space is guaranteed.
                        mem_addr_q <= w_target;
                        state_q    <= FETCH_REQ;
                    end
                end
                default: begin
                    state_q <= FETCH_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_pc_q <= RESET_PC;
        end else if (redirect) begin
            head_pc_q <= redirect_pc;
        end else if (w_pop) begin
            head_pc_q <= pc_inc(head_pc_q);
        end
    end

    byte_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redirect),
        .push_i  (w_push),
        .wdata_i (mem_rdata),
        .pop_i   (w_pop),
        .rdata_o (ib_data),
        .count_o (w_count)
    );

    assign mem_req  = w_in_flight ? BUS_ACTIVE : BUS_IDLE;
    assign mem_addr = mem_addr_q;
    assign ib_valid = (w_count != '0);
    assign ib_pc    = head_pc_q;
    assign ib_count = w_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_prefetch_buffer
//  Description : Self-checking bench for fetch_prefetch_buffer. A queue-based
//                model of the instruction stream is checked every cycle; the
//                directed scenarios add hand-computed expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_prefetch_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             redirect = 1'b0;
    logic [15:0]      redirect_pc = 16'h0000;
    logic             mem_req;
    logic [15:0]      mem_addr;
    logic             mem_ack = 1'b0;
    logic [7:0]       mem_rdata = 8'h00;
    logic             ib_valid;
    logic [7:0]       ib_data;
    logic [15:0]      ib_pc;
    logic             ib_ready = 1'b0;
    logic [CNT_W-1:0] ib_count;

    always #5 clk = ~clk;

    fetch_prefetch_buffer #(
        .DEPTH    (DEPTH),
        .RESET_PC (16'h0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .ib_valid    (ib_valid),
        .ib_data     (ib_data),
        .ib_pc       (ib_pc),
        .ib_ready    (ib_ready),
        .ib_count    (ib_count)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] mem_fn(input logic [15:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    // ---------------- memory responder ----------------
    int          wait_states = 0;
    logic        spurious_ack = 1'b0;
    int          wcnt = 0;
    logic [15:0] acked[$];

    always @(posedge clk) begin
        #1;
        if (mem_req) begin
            if (wcnt >= wait_states) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_fn(mem_addr);
                acked.push_back(mem_addr);
                wcnt      = 0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 8'hEE;
                wcnt++;
            end
        end else begin
            mem_ack   = spurious_ack;
            mem_rdata = 8'hEE;
            wcnt      = 0;
        end
    end

    // ---------------- behavioural model + per-cycle compare ----------------
    typedef struct packed {
        logic [15:0] pc;
        logic [7:0]  data;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] m_fetch = 16'h0000;
    logic [15:0] m_head  = 16'h0000;
    bit          m_drop  = 1'b0;
    bit          prev_valid = 1'b0;
    logic        prev_req, prev_ack;
    logic [15:0] prev_addr;
    logic [15:0] consumed[$];

    always @(negedge clk) begin
        ent_t e;
        if (!rst_n) begin
            mq.delete();
            m_fetch    = 16'h0000;
            m_head     = 16'h0000;
            m_drop     = 1'b0;
            prev_valid = 1'b0;
        end else begin
            chk("ib_count", 32'(ib_count), mq.size());
            chk("ib_valid", 32'(ib_valid), 32'(mq.size() != 0));
            chk("ib_pc", 32'(ib_pc), 32'(m_head));
            if (mq.size() != 0) chk("ib_data", 32'(ib_data), 32'(mq[0].data));
            chk("issue_rule", 32'((int'(ib_count) + int'(mem_req)) <= DEPTH), 32'd1);
            if (mem_req && !m_drop) chk("mem_addr", 32'(mem_addr), 32'(m_fetch));
            if (prev_valid && prev_req && !prev_ack) begin
                chk("req_held", 32'(mem_req), 32'd1);
                chk("addr_held", 32'(mem_addr), 32'(prev_addr));
            end
            prev_valid = 1'b1;
            prev_req   = mem_req;
            prev_ack   = mem_ack;
            prev_addr  = mem_addr;
            // effect of the coming rising edge
            if (redirect) begin
                mq.delete();
                m_head  = redirect_pc;
                m_fetch = redirect_pc;
                if (mem_req && !mem_ack) m_drop = 1'b1;
                else if (mem_req)        m_drop = 1'b0;
            end else begin
                if (mq.size() != 0 && ib_ready) begin
                    consumed.push_back(m_head);
                    void'(mq.pop_front());
                    m_head = m_head + 16'd1;
                end
                if (mem_req && mem_ack) begin
                    if (m_drop) begin
                        m_drop = 1'b0;
                    end else begin
                        e.pc   = m_fetch;
                        e.data = mem_fn(m_fetch);
                        mq.push_back(e);
                        m_fetch = m_fetch + 16'd1;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        acked.delete();
        consumed.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0000);
        chk("rst_ib_valid", 32'(ib_valid), 32'd0);
        chk("rst_ib_count", 32'(ib_count), 32'd0);
        chk("rst_ib_pc", 32'(ib_pc), 32'h0000);

        // 1: zero-wait fill with the core stalled
        wait_states = 0;
        ib_ready    = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (8) step();
        chk("t1_count", 32'(ib_count), 32'd4);
        chk("t1_data", 32'(ib_data), 32'h5A);
        chk("t1_pc", 32'(ib_pc), 32'h0000);
        chk("t1_req_off", 32'(mem_req), 32'd0);
        chk("t1_nreads", acked.size(), 32'd4);
        for (int i = 0; i < 4 && i < acked.size(); i++) chk("t1_walk", 32'(acked[i]), i);
        spurious_ack = 1'b1;
        repeat (3) step();
        spurious_ack = 1'b0;
        chk("t1_spurious_count", 32'(ib_count), 32'd4);
        chk("t1_spurious_req", 32'(mem_req), 32'd0);

        // 2: two wait states, core always ready, 20 bytes in order
        wait_states = 2;
        ib_ready    = 1'b1;
        do_reset();
        for (int n = 0; n < 300 && consumed.size() < 20; n++) step();
        chk("t2_timeout", 32'(consumed.size() >= 20), 32'd1);
        for (int i = 0; i < 20 && i < consumed.size(); i++) chk("t2_stream", 32'(consumed[i]), i);

        // 3: redirect while 0x0003 is outstanding, ack three cycles late
        wait_states = 3;
        ib_ready    = 1'b0;
        do_reset();
        for (int n = 0; n < 100 && !(mem_req && mem_addr == 16'h0003 && !mem_ack); n++) step();
        chk("t3_reach", 32'(mem_req && mem_addr == 16'h0003 && !mem_ack), 32'd1);
        redirect    = 1'b1;
        redirect_pc = 16'h1234;
        step();
        redirect = 1'b0;
        chk("t3_valid", 32'(ib_valid), 32'd0);
        chk("t3_count", 32'(ib_count), 32'd0);
        chk("t3_req_held", 32'(mem_req), 32'd1);
        chk("t3_addr_held", 32'(mem_addr), 32'h0003);
        for (int n = 0; n < 20 && !(mem_req && mem_addr != 16'h0003); n++) step();
        chk("t3_next_addr", 32'(mem_addr), 32'h1234);
        for (int n = 0; n < 20 && !ib_valid; n++) step();
        chk("t3_first_pc", 32'(ib_pc), 32'h1234);
        chk("t3_first_data", 32'(ib_data), 32'h6E);

        // 4: redirect on the ack edge with a pop presented and two bytes queued
        wait_states = 1;
        ib_ready    = 1'b0;
        do_reset();
        for (int n = 0; n < 50 && !(ib_count == 2 && mem_req && mem_ack); n++) step();
        chk("t4_reach", 32'(ib_count == 2 && mem_req && mem_ack), 32'd1);
        redirect    = 1'b1;
        redirect_pc = 16'h0800;
        ib_ready    = 1'b1;
        step();
        redirect = 1'b0;
        ib_ready = 1'b0;
        chk("t4_count", 32'(ib_count), 32'd0);
        chk("t4_valid", 32'(ib_valid), 32'd0);
        chk("t4_req", 32'(mem_req), 32'd1);
        chk("t4_addr", 32'(mem_addr), 32'h0800);
        chk("t4_ib_pc", 32'(ib_pc), 32'h0800);
        for (int n = 0; n < 20 && !ib_valid; n++) step();
        chk("t4_first_data", 32'(ib_data), 32'h5A);

        // 5: wrap through 0xFFFF
        wait_states = 0;
        ib_ready    = 1'b1;
        do_reset();
        repeat (3) step();
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        acked.delete();
        consumed.delete();
        step();
        redirect = 1'b0;
        for (int n = 0; n < 50 && consumed.size() < 4; n++) step();
        chk("t5_timeout", 32'(consumed.size() >= 4 && acked.size() >= 4), 32'd1);
        if (consumed.size() >= 4 && acked.size() >= 4) begin
            chk("t5_pc0", 32'(consumed[0]), 32'hFFFE);
            chk("t5_pc1", 32'(consumed[1]), 32'hFFFF);
            chk("t5_pc2", 32'(consumed[2]), 32'h0000);
            chk("t5_pc3", 32'(consumed[3]), 32'h0001);
            chk("t5_addr0", 32'(acked[0]), 32'hFFFE);
            chk("t5_addr1", 32'(acked[1]), 32'hFFFF);
            chk("t5_addr2", 32'(acked[2]), 32'h0000);
            chk("t5_addr3", 32'(acked[3]), 32'h0001);
        end

        // 6: asynchronous reset between edges during a request
        wait_states = 3;
        ib_ready    = 1'b0;
        do_reset();
        for (int n = 0; n < 50 && !(ib_count >= 1 && mem_req); n++) step();
        chk("t6_reach", 32'(ib_count >= 1 && mem_req), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_req_async", 32'(mem_req), 32'd0);
        chk("t6_valid_async", 32'(ib_valid), 32'd0);
        chk("t6_count_async", 32'(ib_count), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int n = 0; n < 10 && !mem_req; n++) step();
        chk("t6_restart_addr", 32'(mem_addr), 32'h0000);
        for (int n = 0; n < 20 && !ib_valid; n++) step();
        chk("t6_restart_pc", 32'(ib_pc), 32'h0000);
        chk("t6_restart_data", 32'(ib_data), 32'h5A);

        repeat (2) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
